// File: rtl/stack_pointer_unit.sv
// Stack-pointer controller for the data-memory stack segment: tracks the stack top and entry count,
// and produces this cycle's memory address for push, pop, replace, reload and peek operations.
module stack_pointer_unit #(
    parameter int WIDTH   = 32,
    parameter int BASE    = 256,
    parameter int DEPTH   = 64,
    parameter int STEP    = 1,
    parameter int GROW_UP = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [CW-1:0]    load_cnt,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] addr,
    output logic             empty,
    output logic             full,
    output logic             rejected,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    localparam longint SPAN     = longint'(DEPTH) * longint'(STEP);
    localparam longint ADDR_MAX = (WIDTH >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                                : (longint'(1) <<< WIDTH) - 1;

    // The full stack span must fit in the address space in the growth direction.
    generate
        if (DEPTH < 1 ||
            (GROW_UP != 0 && longint'(BASE) + SPAN > ADDR_MAX) ||
            (GROW_UP == 0 && longint'(BASE) < SPAN)) begin : g_range_check
            $error("stack_pointer_unit: BASE/DEPTH/STEP do not fit in WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_LOAD,
        OP_REPLACE,
        OP_PUSH,
        OP_POP
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] top_inc;
    logic [WIDTH-1:0] top_dec;
    logic [CW-1:0]    load_eff;
    logic [WIDTH-1:0] load_off;
    logic [WIDTH-1:0] load_top;
    logic [WIDTH-1:0] top_d;
    logic [CW-1:0]    count_d;
    logic             ovf_set;
    logic             udf_set;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    assign top_inc = (GROW_UP != 0) ? top + STEP_W : top - STEP_W;
    assign top_dec = (GROW_UP != 0) ? top - STEP_W : top + STEP_W;

    assign load_eff = (load_cnt > DEPTH_C) ? DEPTH_C : load_cnt;
    assign load_off = WIDTH'(load_eff) * STEP_W;
    assign load_top = (GROW_UP != 0) ? BASE_W + load_off : BASE_W - load_off;

    always_comb begin
        op = OP_IDLE;
        if (load) begin
            op = OP_LOAD;
        end else if (push && pop) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // Refused moves leave top/count untouched and point addr at top, so memory sees a harmless address.
    always_comb begin
        top_d    = top;
        count_d  = count;
        addr     = top_dec;
        rejected = 1'b0;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        case (op)
            OP_LOAD: begin
                addr    = top;
                top_d   = load_top;
                count_d = load_eff;
                ovf_set = (load_cnt > DEPTH_C);
            end
            OP_REPLACE: begin
                if (empty) begin
                    addr     = top;
                    rejected = 1'b1;
                    udf_set  = 1'b1;
                end
            end
            OP_PUSH: begin
                addr = top;
                if (full) begin
                    rejected = 1'b1;
                    ovf_set  = 1'b1;
                end else begin
                    top_d   = top_inc;
                    count_d = count + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    addr     = top;
                    rejected = 1'b1;
                    udf_set  = 1'b1;
                end else begin
                    top_d   = top_dec;
                    count_d = count - CW'(1);
                end
            end
            default: begin
                addr = top_dec;
            end
        endcase
    end

    // A fresh error beats a simultaneous clear so no fault is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top   <= BASE_W;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            top   <= top_d;
            count <= count_d;
            ovf   <= ovf_set | (ovf & ~err_clr);
            udf   <= udf_set | (udf & ~err_clr);
        end
    end

endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Parametrised stack-pointer controller for the data-memory stack segment. It holds the stack top and a live entry count, and turns push/pop requests into the data-memory address for the current cycle. It detects overflow and underflow and rejects those operations. It supports upward- or downward-growing stacks and a direct pointer reload for context switches. It sits between the control unit's stack micro-operations and the data-memory address mux.

## Interface
Parameters:
- WIDTH, 32: address width of `top` and `addr`.
- BASE, 256: address of the first stack slot. Reset value of `top`.
- DEPTH, 64: maximum number of entries (≥1).
- STEP, 1: address increment per entry (1 = word-addressed).
- GROW_UP, 1: 1 = push increments `top`; 0 = push decrements `top`.
- Derived CW = $clog2(DEPTH+1): width of `count`. BASE ± DEPTH*STEP must fit in WIDTH. This is checked by elaboration assertion.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- push  in  1  push request this cycle.
- pop  in  1  pop request this cycle.
- load  in  1  reload pointer from `load_cnt`.
- load_cnt  in  CW  entry count to load (≤DEPTH).
- err_clr  in  1  clears sticky error flags.
- top  out  WIDTH  registered; next free slot address.
- count  out  CW  registered; current number of entries.
- addr  out  WIDTH  combinational; data-memory address for this cycle's operation.
- empty  out  1  combinational; count==0.
- full  out  1  combinational; count==DEPTH.
- rejected  out  1  combinational; this cycle's request is refused.
- ovf  out  1  registered sticky overflow flag.
- udf  out  1  registered sticky underflow flag.

## Operation
- Let `dec(x)` be x−STEP when GROW_UP=1 and x+STEP when GROW_UP=0. Let `inc(x)` be the opposite. The top-of-stack entry is at dec(top).
- Requests are evaluated every cycle in this priority order: load > push&pop > push > pop > idle.
- **load**: top ← BASE ± load_cnt*STEP, with the sign set by GROW_UP; count ← load_cnt. If load_cnt > DEPTH, the load is clamped to DEPTH and ovf is set. Push and pop are ignored that cycle. addr = top (don't care).
- **push & pop**, when not empty: replace the top of stack. addr = dec(top); top and count are unchanged.
- **push & pop**, when empty: rejected=1, udf set, no change. addr = top.
- **push**, when not full: addr = top; top ← inc(top); count ← count+1.
- **push**, when full: rejected=1, ovf set, no change. addr = top.
- **pop**, when not empty: addr = dec(top); top ← dec(top); count ← count−1.
- **pop**, when empty: rejected=1, udf set, no change. addr = top.
- **idle**: addr = dec(top), so the current top of stack can be peeked. Registers hold.
- rejected is 0 for idle and for accepted operations.
- ovf and udf are sticky. err_clr clears them. If err_clr coincides with a new error, the new error wins and the flag stays 1.
- Invariant: top == BASE ± count*STEP at all times. The pointer never wraps, because full and empty block out-of-range moves.

## Timing
- Reset values (rst_n=0 sampled at a posedge): top=BASE, count=0, ovf=0, udf=0. Hence empty=1, full=0, and addr=dec(BASE) when idle. Reset overrides every request in the same cycle.
- Reset applied mid-sequence discards all pending state at that edge. No partial update.
- addr, rejected, empty and full are combinational from the current registers and inputs. They are valid in the same cycle as the request, with zero latency, so memory access happens in the request cycle.
- top, count and flags update on the rising edge at the end of the request cycle. Back-to-back operations every cycle are supported with no bubbles.
- One operation per cycle. Inputs are sampled only at the posedge.

## Test plan
Bench parameters: BASE=256, DEPTH=4, STEP=1, GROW_UP=1 unless stated.
- Reset then idle: top=256, count=0, empty=1, full=0, ovf=udf=0, addr=255.
- Push ×4: addr=256,257,258,259 in successive cycles; after the 4th push top=260, count=4, full=1. A 5th push gives rejected=1, ovf=1, top stays 260.
- From full, pop ×4: addr=259,258,257,256; top=256, empty=1. A 5th pop gives rejected=1, udf=1. Then err_clr clears udf. err_clr together with a rejected pop keeps udf=1.
- Push&pop with count=2 (top=258): addr=257, top and count unchanged. Push&pop when empty: udf=1, no change.
- load with load_cnt=3: top=259, count=3. load_cnt=7: clamped to top=260, count=4, ovf=1. load asserted together with push gives the load result only.
- GROW_UP=0, BASE=1023: two pushes give addr=1023, then 1022, leaving top=1021. One pop gives addr=1022, top=1022. Assert rst_n=0 alongside a push: next state is top=1023, count=0.
